// File: rtl/lrc_param_check.sv
// Left-right disparity consistency check: flags occluded / mismatched pixels with a fixed 3-cycle latency.
// Optional hole filling of flagged pixels is compiled in with `define LRC_HOLE_FILL_EN.
module lrc_param_check #(
  parameter int DW   = 7,
  parameter int FRAC = 1,
  parameter int AW   = 9,
  parameter int TW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          sol,
  input  logic [AW-1:0] line_len,
  input  logic [TW-1:0] thresh,
  input  logic [DW-1:0] disp_l,
  input  logic [DW-1:0] disp_r,
  output logic          out_valid,
  output logic [DW+1:0] out_disp,
  output logic          out_eol
);

  localparam int IW = DW - FRAC;
  localparam int CW = (IW + 1 > TW) ? IW + 1 : TW;
  localparam int XW = (AW > IW) ? AW + 1 : IW + 1;
  localparam logic [AW-1:0] ONE = AW'(1);

  function automatic logic [IW-1:0] int_part(input logic [DW-1:0] d);
    return d[DW-1:FRAC];
  endfunction

  // One bit of headroom so the difference of two IW-bit integers never wraps.
  function automatic logic [IW:0] abs_diff(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [IW:0] ea, eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return (ea >= eb) ? (ea - eb) : (eb - ea);
  endfunction

  logic [DW-1:0] rbuf [0:(1<<AW)-1];

  logic [AW-1:0] x_cnt, x_cur;
  logic          eol_cur;
  logic          vld_p0, vld_p1, vld_p2;
  logic [DW-1:0] dl_p0, dl_p1, dl_p2, rd_p1;
  logic [AW-1:0] x_p0;
  logic [TW-1:0] th_p0, th_p1;
  logic          eol_p0, eol_p1, eol_p2;
  logic          lst_p0, lst_p1, lst_p2;
  logic          oob_p1;
  logic [1:0]    flags_p2;

  assign x_cur   = sol ? '0 : x_cnt;
  assign eol_cur = (x_cur == (line_len - ONE));

  // Stage p0: accept pixel, store right disparity, capture left side.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      rbuf[x_cur] <= disp_r;
      dl_p0       <= disp_l;
      x_p0        <= x_cur;
      th_p0       <= thresh;
      eol_p0      <= eol_cur;
      lst_p0      <= (x_cur == '0);
    end
  end

  logic [IW-1:0] dli_p0;
  logic [XW-1:0] xr_full;
  logic          oob_c;

  assign dli_p0  = int_part(dl_p0);
  assign oob_c   = XW'(dli_p0) > XW'(x_p0);
  assign xr_full = XW'(x_p0) - XW'(dli_p0);

  // Stage p1: synchronous read of the matching right-image column.
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      if (!oob_c)
        rd_p1 <= rbuf[xr_full[AW-1:0]];
      oob_p1 <= oob_c;
      dl_p1  <= dl_p0;
      th_p1  <= th_p0;
      eol_p1 <= eol_p0;
      lst_p1 <= lst_p0;
    end
  end

  logic [IW-1:0] dli_p1, dri_p1;
  logic [1:0]    flags_c;

  assign dli_p1 = int_part(dl_p1);
  assign dri_p1 = int_part(rd_p1);

  always_comb begin
    flags_c = 2'b01;
    if (oob_p1)
      flags_c = 2'b10;
    else if (CW'(abs_diff(dli_p1, dri_p1)) <= CW'(th_p1))
      flags_c = 2'b00;
    else if (dli_p1 < dri_p1)
      flags_c = 2'b10;
  end

  // Stage p2: classification result.
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      flags_p2 <= flags_c;
      dl_p2    <= dl_p1;
      eol_p2   <= eol_p1;
      lst_p2   <= lst_p1;
    end
  end

  logic [DW-1:0] disp_sel;

`ifdef LRC_HOLE_FILL_EN
  logic [DW-1:0] fill_q;

  assign disp_sel = (flags_p2 == 2'b00) ? dl_p2 : (lst_p2 ? '0 : fill_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fill_q <= '0;
    else if (vld_p2 && flags_p2 == 2'b00)
      fill_q <= dl_p2;
    else if (vld_p2 && lst_p2)
      fill_q <= '0;
  end
`else
  logic unused_lst;

  assign disp_sel   = dl_p2;
  assign unused_lst = lst_p2;
`endif

  // Stage p3: output register, held while no pixel retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt     <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      out_valid <= 1'b0;
      out_disp  <= '0;
      out_eol   <= 1'b0;
    end else begin
      if (in_valid)
        x_cnt <= eol_cur ? '0 : (x_cur + ONE);
      vld_p0    <= in_valid;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
      out_valid <= vld_p2;
      if (vld_p2) begin
        out_disp <= {flags_p2, disp_sel};
        out_eol  <= eol_p2;
      end
    end
  end

endmodule

// File: tb/tb_lrc_param_check.sv
// Directed bench for lrc_param_check with default parameters (DW=7, FRAC=1, AW=9, TW=4).
module tb_lrc_param_check;

`ifdef LRC_HOLE_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, sol;
  logic [8:0] line_len;
  logic [3:0] thresh;
  logic [6:0] disp_l, disp_r;
  logic       out_valid;
  logic [8:0] out_disp;
  logic       out_eol;

  int n_vec = 0;
  int n_bad = 0;
  int ncnt  = 0;

  logic       lv [0:4095];
  logic [8:0] ld [0:4095];
  logic       le [0:4095];

  lrc_param_check dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sol(sol),
    .line_len(line_len), .thresh(thresh), .disp_l(disp_l), .disp_r(disp_r),
    .out_valid(out_valid), .out_disp(out_disp), .out_eol(out_eol)
  );

  always #5 clk = ~clk;

  // ncnt = number of rising edges so far; outputs logged at each falling edge.
  always @(posedge clk) ncnt <= ncnt + 1;

  always @(negedge clk) begin
    lv[ncnt] = out_valid;
    ld[ncnt] = out_disp;
    le[ncnt] = out_eol;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Pixel accepted at rising edge e; its result is logged at index e+3.
  task automatic px(input logic s, input logic [6:0] dl, input logic [6:0] dr, output int e);
    @(negedge clk);
    in_valid = 1'b1;
    sol      = s;
    disp_l   = dl;
    disp_r   = dr;
    e        = ncnt + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      sol      = 1'b0;
    end
  endtask

  task automatic chk_px(input string tag, input int e, input logic [8:0] xd, input logic xe);
    check({tag, ".v"},   16'(lv[e+3]), 16'd1);
    check({tag, ".d"},   16'(ld[e+3]), 16'(xd));
    check({tag, ".eol"}, 16'(le[e+3]), 16'(xe));
  endtask

  int e [0:31];
  int e0, e1, m;

  initial begin
    rst = 1'b1; in_valid = 1'b0; sol = 1'b0;
    line_len = 9'd8; thresh = 4'd1; disp_l = '0; disp_r = '0;
    #2;
    check("rst.v",   16'(out_valid), 16'd0);
    check("rst.d",   16'(out_disp),  16'd0);
    check("rst.eol", 16'(out_eol),   16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);

    // 8-pixel line, all disparities int 2: columns 0,1 out of bounds.
    line_len = 9'd8; thresh = 4'd1;
    for (int i = 0; i < 8; i++) px(i == 0, 7'd4, 7'd4, e[i]);
    idle(6);
    check("t1.lat_pre", 16'(lv[e[0]+2]), 16'd0);
    for (int i = 0; i < 8; i++)
      chk_px($sformatf("t1.c%0d", i), e[i],
             (i < 2) ? (FILL ? 9'h100 : 9'h104) : 9'h004, i == 7);

    // Column 10, dLi=3, reads column 7 with dRi = 6, 1, 2.
    line_len = 9'd16; thresh = 4'd1;
    for (int v = 0; v < 3; v++) begin
      logic [6:0] dr7;
      logic [8:0] xd;
      dr7 = (v == 0) ? 7'd12 : (v == 1) ? 7'd2 : 7'd4;
      xd  = (v == 0) ? (FILL ? 9'h100 : 9'h106) :
            (v == 1) ? (FILL ? 9'h080 : 9'h086) : 9'h006;
      for (int c = 0; c < 16; c++)
        px(c == 0, (c == 10) ? 7'd6 : 7'd0, (c == 7) ? dr7 : 7'd0, e[c]);
      idle(5);
      chk_px($sformatf("t2.v%0d", v), e[10], xd, 1'b0);
    end

    // sol re-asserted at column 5 of a 16-pixel line.
    line_len = 9'd16; thresh = 4'd1;
    for (int i = 0; i < 21; i++) px(i == 0 || i == 5, 7'd2, 7'd2, e[i]);
    idle(5);
    chk_px("t3.c0",   e[0],  FILL ? 9'h100 : 9'h102, 1'b0);
    chk_px("t3.c4",   e[4],  9'h002, 1'b0);
    chk_px("t3.sol",  e[5],  FILL ? 9'h100 : 9'h102, 1'b0);
    chk_px("t3.n1",   e[6],  9'h002, 1'b0);
    chk_px("t3.old15", e[15], 9'h002, 1'b0);
    chk_px("t3.eol",  e[20], 9'h002, 1'b1);

    // in_valid 1,0,0,1 -> out_valid 1,0,0,1 with held outputs in the gap.
    line_len = 9'd4;
    px(1'b1, 7'd6, 7'd0, e0);
    idle(2);
    px(1'b0, 7'd0, 7'd0, e1);
    idle(5);
    chk_px("t4.p0", e0, FILL ? 9'h100 : 9'h106, 1'b0);
    check("t4.g1.v", 16'(lv[e0+4]), 16'd0);
    check("t4.g1.d", 16'(ld[e0+4]), FILL ? 16'h100 : 16'h106);
    check("t4.g2.v", 16'(lv[e0+5]), 16'd0);
    check("t4.g2.d", 16'(ld[e0+5]), FILL ? 16'h100 : 16'h106);
    check("t4.g2.eol", 16'(le[e0+5]), 16'd0);
    check("t4.p1.at", 16'(e1 - e0), 16'd3);
    chk_px("t4.p1", e1, 9'h000, 1'b0);

    // Disparity 8 (int 4) needs x>=4 to stay in bounds: good column 9, mismatch column 10.
    line_len = 9'd16; thresh = 4'd1;
    for (int c = 0; c < 11; c++)
      px(c == 0, (c == 0) ? 7'd2 : (c == 9) ? 7'd8 : (c == 10) ? 7'd12 : 7'd0,
         (c == 5) ? 7'd8 : 7'd0, e[c]);
    idle(5);
    chk_px("t5.c0",  e[0],  FILL ? 9'h100 : 9'h102, 1'b0);
    chk_px("t5.c9",  e[9],  9'h008, 1'b0);
    chk_px("t5.c10", e[10], FILL ? 9'h088 : 9'h08C, 1'b0);

    // Reset mid-line with two pixels still in the pipeline.
    line_len = 9'd16;
    for (int i = 0; i < 4; i++) px(i == 0, 7'd2, 7'd2, e[i]);
    idle(2);
    check("t6.pre.v", 16'(out_valid), 16'd1);
    check("t6.pre.d", 16'(out_disp), 16'h002);
    #1 rst = 1'b1;
    #1;
    check("t6.rst.v",   16'(out_valid), 16'd0);
    check("t6.rst.d",   16'(out_disp),  16'd0);
    check("t6.rst.eol", 16'(out_eol),   16'd0);
    idle(2);
    rst = 1'b0;
    m = ncnt;
    idle(4);
    for (int k = m - 1; k <= m + 3; k++)
      check($sformatf("t6.stale%0d", k - m), 16'(lv[k]), 16'd0);
    px(1'b0, 7'd2, 7'd2, e0);
    idle(5);
    chk_px("t6.x0", e0, FILL ? 9'h100 : 9'h102, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
